// File: rtl/nes_clock_sequencer.sv
// Power-up / recovery sequencer for the NES clock PLL, clocked by the 50 MHz reference.
// Optional NES_CLKSEQ_AUTO_RELOCK_EN: lock loss in RUN/SOFT_RST re-runs the PLL bring-up instead of faulting.
module nes_clock_sequencer #(
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 50000,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int MAX_RETRIES         = 3,
  parameter int SOFT_RST_CYCLES     = 64
) (
  input  logic                                 refclk,
  input  logic                                 rst,
  input  logic                                 pll_locked,
  input  logic                                 soft_reset_req,
  output logic                                 pll_rst,
  output logic                                 sys_rst,
  output logic                                 clocks_ready,
  output logic                                 fault,
  output logic [$clog2(MAX_RETRIES+1)-1:0]     retry_cnt,
  output logic [2:0]                           state_dbg
);

  localparam int MAX_A   = (PLL_RST_CYCLES > LOCK_TIMEOUT_CYCLES) ? PLL_RST_CYCLES : LOCK_TIMEOUT_CYCLES;
  localparam int MAX_B   = (LOCK_STABLE_CYCLES > SOFT_RST_CYCLES) ? LOCK_STABLE_CYCLES : SOFT_RST_CYCLES;
  localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int RW      = $clog2(MAX_RETRIES + 1);

  localparam logic [CW-1:0] PLL_RST_LAST = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] STABLE_LAST  = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] SOFT_LAST    = CW'(SOFT_RST_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_LIMIT  = RW'(MAX_RETRIES);

  typedef enum logic [2:0] {
    ST_PLL_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_SOFT_RST  = 3'd4,
    ST_FAULT     = 3'd5
  } state_e;

`ifdef NES_CLKSEQ_AUTO_RELOCK_EN
  localparam state_e LOSS_STATE = ST_PLL_RST;
`else
  localparam state_e LOSS_STATE = ST_FAULT;
`endif

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [RW-1:0]   retry_q, retry_d;
  logic [1:0]      sync_q;
  logic            lock_s;
  logic            pll_rst_d, sys_rst_d, clocks_ready_d, fault_d;

  assign lock_s    = sync_q[1];
  assign retry_cnt = retry_q;
  assign state_dbg = state_q;

  // Next-state, retry bookkeeping, shared counter and output decode of the next state.
  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    case (state_q)
      ST_PLL_RST: begin
        if (cnt_q == PLL_RST_LAST) state_d = ST_WAIT_LOCK;
        else                       state_d = ST_PLL_RST;
      end
      ST_WAIT_LOCK: begin
        if (lock_s) begin
          state_d = ST_STABLE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          if (retry_q == RETRY_LIMIT) begin
            state_d = ST_FAULT;
          end else begin
            state_d = ST_PLL_RST;
            retry_d = retry_q + RW'(1);
          end
        end else begin
          state_d = ST_WAIT_LOCK;
        end
      end
      ST_STABLE: begin
        if (!lock_s) begin
          state_d = ST_WAIT_LOCK;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = ST_RUN;
          retry_d = {RW{1'b0}};
        end else begin
          state_d = ST_STABLE;
        end
      end
      ST_RUN: begin
        // Lock loss outranks a simultaneous soft reset request.
        if (!lock_s) begin
          state_d = LOSS_STATE;
          retry_d = {RW{1'b0}};
        end else if (soft_reset_req) begin
          state_d = ST_SOFT_RST;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_SOFT_RST: begin
        if (!lock_s) begin
          state_d = LOSS_STATE;
          retry_d = {RW{1'b0}};
        end else if (cnt_q == SOFT_LAST) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_SOFT_RST;
        end
      end
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_FAULT;
    endcase

    // RUN and FAULT have no terminal count, so the counter holds there.
    if (state_d != state_q) begin
      cnt_d = {CW{1'b0}};
    end else if (state_q == ST_RUN || state_q == ST_FAULT) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end

    pll_rst_d      = (state_d == ST_PLL_RST) || (state_d == ST_FAULT);
    sys_rst_d      = (state_d != ST_RUN);
    clocks_ready_d = (state_d == ST_RUN);
    fault_d        = (state_d == ST_FAULT);
  end

  // State, counter, lock synchronizer and registered Moore outputs.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q      <= ST_PLL_RST;
      cnt_q        <= {CW{1'b0}};
      retry_q      <= {RW{1'b0}};
      sync_q       <= 2'b00;
      pll_rst      <= 1'b1;
      sys_rst      <= 1'b1;
      clocks_ready <= 1'b0;
      fault        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      retry_q      <= retry_d;
      sync_q       <= {sync_q[0], pll_locked};
      pll_rst      <= pll_rst_d;
      sys_rst      <= sys_rst_d;
      clocks_ready <= clocks_ready_d;
      fault        <= fault_d;
    end
  end

endmodule

// File: tb/tb_nes_clock_sequencer.sv
// Randomized + directed bench for nes_clock_sequencer against a timestamp-based reference model.
// Honours NES_CLKSEQ_AUTO_RELOCK_EN the same way the design does.
module tb_nes_clock_sequencer;

  localparam int PRC = 4;
  localparam int LTC = 32;
  localparam int LSC = 8;
  localparam int MR  = 2;
  localparam int SRC = 6;

  localparam int S_PLL = 0, S_WAIT = 1, S_STABLE = 2, S_RUN = 3, S_SOFT = 4, S_FAULT = 5;
`ifdef NES_CLKSEQ_AUTO_RELOCK_EN
  localparam int S_LOSS = S_PLL;
`else
  localparam int S_LOSS = S_FAULT;
`endif

  logic       refclk = 1'b0;
  logic       rst = 1'b1;
  logic       pll_locked = 1'b0;
  logic       soft_reset_req = 1'b0;
  logic       pll_rst, sys_rst, clocks_ready, fault;
  logic [1:0] retry_cnt;
  logic [2:0] state_dbg;

  always #10 refclk = ~refclk;

  nes_clock_sequencer #(
    .PLL_RST_CYCLES(PRC), .LOCK_TIMEOUT_CYCLES(LTC), .LOCK_STABLE_CYCLES(LSC),
    .MAX_RETRIES(MR), .SOFT_RST_CYCLES(SRC)
  ) dut (
    .refclk(refclk), .rst(rst), .pll_locked(pll_locked), .soft_reset_req(soft_reset_req),
    .pll_rst(pll_rst), .sys_rst(sys_rst), .clocks_ready(clocks_ready), .fault(fault),
    .retry_cnt(retry_cnt), .state_dbg(state_dbg)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: edge counter, entry timestamp of the current state, lock sample history.
  int   cyc = 0;
  int   m_state = S_PLL;
  int   m_entry = 0;
  int   m_retry = 0;
  logic hist[$];

  task automatic model_edge(input logic r, input logic lk, input logic sr);
    logic ls;
    int   age;
    int   nxt;
    if (r) begin
      m_state = S_PLL;
      m_retry = 0;
      m_entry = cyc + 1;
      hist.delete();
      hist.push_back(1'b0);
      hist.push_back(1'b0);
    end else begin
      ls = hist[$-1];
      hist.push_back(lk);
      if (hist.size() > 4) void'(hist.pop_front());
      age = cyc - m_entry;
      nxt = m_state;
      if (m_state == S_PLL) begin
        if (age == PRC - 1) nxt = S_WAIT;
      end else if (m_state == S_WAIT) begin
        if (ls) nxt = S_STABLE;
        else if (age == LTC - 1) begin
          if (m_retry == MR) nxt = S_FAULT;
          else begin
            m_retry++;
            nxt = S_PLL;
          end
        end
      end else if (m_state == S_STABLE) begin
        if (!ls) nxt = S_WAIT;
        else if (age == LSC - 1) begin
          nxt = S_RUN;
          m_retry = 0;
        end
      end else if (m_state == S_RUN || m_state == S_SOFT) begin
        if (!ls) begin
          nxt = S_LOSS;
          m_retry = 0;
        end else if (m_state == S_RUN && sr) nxt = S_SOFT;
        else if (m_state == S_SOFT && age == SRC - 1) nxt = S_RUN;
      end
      if (nxt != m_state) begin
        m_state = nxt;
        m_entry = cyc + 1;
      end
    end
    cyc++;
  endtask

  function automatic logic [15:0] model_vec();
    logic pr, sy, cr, ft;
    pr = (m_state == S_PLL) || (m_state == S_FAULT);
    sy = (m_state != S_RUN);
    cr = (m_state == S_RUN);
    ft = (m_state == S_FAULT);
    return {7'd0, pr, sy, cr, ft, 2'(m_retry), 3'(m_state)};
  endfunction

  function automatic logic [15:0] dut_vec();
    return {7'd0, pll_rst, sys_rst, clocks_ready, fault, retry_cnt, state_dbg};
  endfunction

  task automatic tick(input logic r, input logic lk, input logic sr, input string tag);
    rst = r;
    pll_locked = lk;
    soft_reset_req = sr;
    @(posedge refclk);
    model_edge(r, lk, sr);
    @(negedge refclk);
    check_eq(tag, dut_vec(), model_vec());
  endtask

  int  n;
  int  saw_soft;
  int  mode;
  int  len;
  logic lk_r;

  initial begin
    // Reset and clean bring-up.
    repeat (2) tick(1'b1, 1'b0, 1'b0, "reset");
    check_eq("reset_values", dut_vec(), 16'h0180);
    repeat (10) tick(1'b0, 1'b0, 1'b0, "pre_lock");
    n = 0;
    while (!clocks_ready && n < 40) begin
      tick(1'b0, 1'b1, 1'b0, "bringup");
      n++;
    end
    check_eq("bringup_latency", 16'(n), 16'd11);
    check_eq("bringup_retry", 16'(retry_cnt), 16'd0);

    // Soft reset with a second request mid-pulse.
    repeat (3) tick(1'b0, 1'b1, 1'b0, "run");
    tick(1'b0, 1'b1, 1'b1, "soft_req");
    n = 0;
    while (sys_rst && n < 20) begin
      tick(1'b0, 1'b1, (n == 2) ? 1'b1 : 1'b0, "soft_rst");
      n++;
    end
    check_eq("soft_rst_width", 16'(n), 16'd6);
    check_eq("soft_rst_pll", 16'(pll_rst), 16'd0);

    // Lock loss together with a soft reset request: no SOFT_RST visit.
    repeat (3) tick(1'b0, 1'b1, 1'b0, "run2");
    saw_soft = 0;
    tick(1'b0, 1'b0, 1'b0, "loss0");
    tick(1'b0, 1'b0, 1'b0, "loss1");
    tick(1'b0, 1'b0, 1'b1, "loss_soft");
    if (state_dbg == 3'd4) saw_soft = 1;
    check_eq("loss_sys_rst", 16'(sys_rst), 16'd1);
`ifdef NES_CLKSEQ_AUTO_RELOCK_EN
    check_eq("loss_relock_pll_rst", 16'(pll_rst), 16'd1);
    for (int i = 0; i < 30; i++) begin
      tick(1'b0, 1'b1, 1'b0, "relock");
      if (state_dbg == 3'd4) saw_soft = 1;
    end
    check_eq("relock_ready", 16'(clocks_ready), 16'd1);
`else
    check_eq("loss_fault", 16'(fault), 16'd1);
`endif
    check_eq("no_soft_rst", 16'(saw_soft), 16'd0);

    // Glitch in STABLE after 5 stable cycles, then uninterrupted lock.
    tick(1'b1, 1'b0, 1'b0, "reset2");
    repeat (4) tick(1'b0, 1'b1, 1'b0, "glitch_pre");
    repeat (4) tick(1'b0, 1'b1, 1'b0, "glitch_stable");
    tick(1'b0, 1'b0, 1'b0, "glitch_drop");
    n = 0;
    while (!clocks_ready && n < 40) begin
      tick(1'b0, 1'b1, 1'b0, "glitch_recover");
      n++;
    end
    check_eq("glitch_recover_latency", 16'(n), 16'd11);

    // Timeouts until FAULT, which survives a late lock and clears only on reset.
    tick(1'b1, 1'b0, 1'b0, "reset3");
    repeat (3 * (PRC + LTC) + 4) tick(1'b0, 1'b0, 1'b0, "timeout");
    check_eq("timeout_fault", 16'(fault), 16'd1);
    repeat (20) tick(1'b0, 1'b1, 1'b0, "fault_hold");
    check_eq("fault_sticky", {12'd0, pll_rst, sys_rst, clocks_ready, fault}, 16'h000D);
    tick(1'b1, 1'b1, 1'b0, "fault_rst");
    check_eq("fault_rst_values", dut_vec(), 16'h0180);

    // Reset in the middle of STABLE.
    repeat (10) tick(1'b0, 1'b1, 1'b0, "mid_pre");
    tick(1'b1, 1'b1, 1'b0, "mid_rst");
    check_eq("mid_rst_values", dut_vec(), 16'h0180);

    // Randomized segments.
    for (int s = 0; s < 40; s++) begin
      mode = $urandom_range(0, 3);
      len  = $urandom_range(5, 120);
      if (m_state == S_FAULT && $urandom_range(0, 1) == 1) tick(1'b1, 1'b0, 1'b0, "rand_rst");
      for (int i = 0; i < len; i++) begin
        case (mode)
          0:       lk_r = 1'b1;
          1:       lk_r = 1'b0;
          2:       lk_r = ($urandom_range(0, 7) != 0);
          default: lk_r = 1'($urandom_range(0, 1));
        endcase
        tick(($urandom_range(0, 299) == 0), lk_r, ($urandom_range(0, 15) == 0), "random");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/nes_clock_sequencer.md
Name: nes_clock_sequencer

Overview:
- Power-up and recovery sequencer for the NES clock PLL (50 MHz ref -> 5.369458 MHz and 1.789819 MHz outputs).
- Runs on the 50 MHz reference clock and drives the PLL reset.
- Qualifies and debounces the PLL locked flag, then releases the NES core reset only once the derived clocks are stable.
- Handles lock-timeout retries, lock loss and software-requested core resets; reports status and fault.

Parameters:
- PLL_RST_CYCLES, 16: refclk cycles pll_rst is held high per PLL reset attempt (>=1).
- LOCK_TIMEOUT_CYCLES, 50000: refclk cycles (1 ms) to wait for synchronized lock before the attempt fails (>=2).
- LOCK_STABLE_CYCLES, 1024: consecutive cycles synchronized lock must stay high before release (>=1).
- MAX_RETRIES, 3: failed attempts allowed after the first before FAULT (>=1).
- SOFT_RST_CYCLES, 64: sys_rst pulse width for a soft reset (>=1).

Ports:
- refclk  in  1  50 MHz reference clock; sole clock of the block.
- rst  in  1  synchronous, active-high reset.
- pll_locked  in  1  PLL locked flag; asynchronous, 2-flop synchronized internally to lock_s.
- soft_reset_req  in  1  single-cycle request to reset the NES core without touching the PLL.
- pll_rst  out  1  reset to the PLL.
- sys_rst  out  1  NES core reset (active-high).
- clocks_ready  out  1  high only in RUN.
- fault  out  1  sticky PLL failure flag.
- retry_cnt  out  $clog2(MAX_RETRIES+1)  failed attempts since last RUN entry.
- state_dbg  out  3  current state encoding.

Behaviour:
- One clock (refclk); reset is synchronous and active-high (rst). All logic samples rst on the refclk rising edge.
- Outputs are registered Moore decodes of the state register. No combinational input-to-output path.
- pll_locked -> lock_s latency: 2 cycles. All lock decisions use lock_s only.
- Single shared counter cnt, cleared on every state change.
- On rst: state=PLL_RST, cnt=0, retry_cnt=0, pll_rst=1, sys_rst=1, clocks_ready=0, fault=0, state_dbg=0. The synchronizer flops clear to 0.
- PLL_RST (0): pll_rst=1, sys_rst=1. When cnt==PLL_RST_CYCLES-1 -> WAIT_LOCK.
- WAIT_LOCK (1): pll_rst=0, sys_rst=1.
  - lock_s=1 -> STABLE.
  - Else when cnt==LOCK_TIMEOUT_CYCLES-1: if retry_cnt==MAX_RETRIES -> FAULT; otherwise retry_cnt+=1 -> PLL_RST.
- STABLE (2): pll_rst=0, sys_rst=1.
  - lock_s=0 -> WAIT_LOCK with a fresh timeout window; retry_cnt unchanged.
  - When cnt==LOCK_STABLE_CYCLES-1 with lock_s=1 -> RUN.
- RUN (3): pll_rst=0, sys_rst=0, clocks_ready=1. retry_cnt clears on entry.
  - lock_s=0 is a lock loss; handling is defined under Optional Feature.
  - soft_reset_req=1 -> SOFT_RST.
  - Lock loss has priority over soft_reset_req in the same cycle.
- SOFT_RST (4): pll_rst=0, sys_rst=1, clocks_ready=0.
  - When cnt==SOFT_RST_CYCLES-1 -> RUN.
  - lock_s=0 during SOFT_RST is treated as a lock loss, same as in RUN.
  - soft_reset_req while in SOFT_RST is ignored (pulse is not extended).
- FAULT (5): pll_rst=1, sys_rst=1, clocks_ready=0, fault=1. Exit only via rst.
- soft_reset_req is ignored in every state except RUN.
- clocks_ready and sys_rst are always complementary, except in FAULT where both are deasserted-ready/asserted-reset.
- rst mid-operation (any state, including FAULT) aborts within one cycle to the reset values above.
- Counter width: $clog2 of the largest of the four cycle parameters. cnt never wraps because every state exits at its terminal count.

Optional Feature:
- Macro: NES_CLKSEQ_AUTO_RELOCK_EN.
- Defined: lock loss in RUN/SOFT_RST -> PLL_RST, with retry_cnt starting at 0. The full retry/timeout sequence applies; sys_rst is reasserted the same cycle the state leaves RUN.
- Undefined: lock loss in RUN/SOFT_RST -> FAULT immediately. Only initial power-up uses retries.

Test Plan (PLL_RST_CYCLES=4, LOCK_TIMEOUT_CYCLES=32, LOCK_STABLE_CYCLES=8, MAX_RETRIES=2, SOFT_RST_CYCLES=6):
- Clean bring-up: release rst, raise pll_locked 10 cycles later and hold -> pll_rst high exactly 4 cycles after release; clocks_ready rises 2+8 cycles after pll_locked rises, plus 1 cycle for the STABLE entry transition; sys_rst falls the same cycle; retry_cnt=0.
- Lock glitch: in STABLE, drop pll_locked 1 cycle after 5 stable cycles -> return to WAIT_LOCK, stable count restarts; clocks_ready only after 8 uninterrupted cycles.
- Timeouts: pll_locked held 0 -> PLL_RST/WAIT_LOCK repeats 3 times with retry_cnt 0->1->2; then FAULT: fault=1, pll_rst=1, sys_rst=1. FAULT persists with pll_locked raised; cleared only by rst.
- Soft reset: in RUN pulse soft_reset_req -> sys_rst high exactly 6 cycles, clocks_ready low for those 6, pll_rst stays 0. A second pulse mid-SOFT_RST does not extend it.
- Lock loss in RUN: drop pll_locked -> 2 cycles later sys_rst=1. With NES_CLKSEQ_AUTO_RELOCK_EN: state PLL_RST, pll_rst=1 for 4 cycles, then re-lock reaches RUN. Without it: fault=1.
- Simultaneous lock loss and soft_reset_req in RUN -> lock-loss path taken, SOFT_RST never entered; mid-sequence rst -> all outputs at reset values next cycle.
